// File: rtl/ppm_pkg.sv
// Shared encodings, widths and default slot timing for the PPM frame scheduler.
package ppm_pkg;

   localparam int unsigned SOF_CLKS_DEF  = 128;
   localparam int unsigned SYM_CLKS_DEF  = 128;
   localparam int unsigned EOF_CLKS_DEF  = 64;
   localparam int unsigned GAP_CLKS_DEF  = 16;
   localparam int unsigned MAX_BYTES_DEF = 16;

   localparam int unsigned SLOT_W = 10;
   localparam int unsigned BCNT_W = 5;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned SYM_W  = 2;

   typedef enum logic [1:0] {
      ORD_IDLE = 2'b00,
      ORD_SOF  = 2'b01,
      ORD_DATA = 2'b10,
      ORD_EOF  = 2'b11
   } order_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SOF  = 3'd1,
      ST_DATA = 3'd2,
      ST_EOF  = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   // One source beat: byte plus end-of-frame marker.
   typedef struct packed {
      logic              last;
      logic [BYTE_W-1:0] data;
   } beat_t;

endpackage

// File: rtl/ppm_rr_arb.sv
// Two-requester round-robin arbiter; the pointer favours the source not served last.
module ppm_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       served_s0,
   output logic [1:0] gnt_c
);

   logic ptr_q;   // 1 = source 1 wins a tie

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     ptr_q <= 1'b0;
      else if (upd) ptr_q <= served_s0;
   end

   always_comb begin
      gnt_c = req;
      if (req == 2'b11) gnt_c = ptr_q ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/ppm_frame_scheduler.sv
// Frames source bytes into SOF / 2-bit PPM DATA symbols / EOF / GAP slots for the encoder.
module ppm_frame_scheduler
   import ppm_pkg::*;
#(
   parameter int unsigned SOF_CLKS  = SOF_CLKS_DEF,
   parameter int unsigned SYM_CLKS  = SYM_CLKS_DEF,
   parameter int unsigned EOF_CLKS  = EOF_CLKS_DEF,
   parameter int unsigned GAP_CLKS  = GAP_CLKS_DEF,
   parameter int unsigned MAX_BYTES = MAX_BYTES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s0_valid,
   input  logic [7:0] s0_data,
   input  logic       s0_last,
   output logic       s0_ready,
   input  logic       s1_valid,
   input  logic [7:0] s1_data,
   input  logic       s1_last,
   output logic       s1_ready,
   output logic [1:0] order,
   output logic [9:0] slot_cnt,
   output logic [1:0] sym_idx,
   output logic [7:0] tx_byte,
   output logic [1:0] grant,
   output logic       busy,
   output logic       frame_err
);

   state_t              state_q, state_n;
   order_t              order_q, order_n;
   logic [SLOT_W-1:0]   slot_q, slot_n;
   logic [SYM_W-1:0]    sym_q, sym_n;
   logic [BYTE_W-1:0]   byte_q, byte_n;
   logic [1:0]          grant_q, grant_n;
   logic                busy_q, busy_n;
   logic                err_q, err_n;
   logic                last_q, last_n;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_n;

   logic [1:0] arb_gnt_c;
   logic       arb_upd_c;
   logic       src_sel_c;
   logic       gnt_valid_c;
   beat_t      sel_beat_c;

   ppm_rr_arb u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       ({s1_valid, s0_valid}),
      .upd       (arb_upd_c),
      .served_s0 (grant_q[0]),
      .gnt_c     (arb_gnt_c)
   );

   // In IDLE the arbiter picks the source; mid-frame only the owner is looked at.
   assign src_sel_c   = (state_q == ST_IDLE) ? arb_gnt_c[1] : grant_q[1];
   assign sel_beat_c  = src_sel_c ? beat_t'({s1_last, s1_data}) : beat_t'({s0_last, s0_data});
   assign gnt_valid_c = |(grant_q & {s1_valid, s0_valid});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         order_q <= ORD_IDLE;
         slot_q  <= '0;
         sym_q   <= '0;
         byte_q  <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         last_q  <= 1'b0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_n;
         order_q <= order_n;
         slot_q  <= slot_n;
         sym_q   <= sym_n;
         byte_q  <= byte_n;
         grant_q <= grant_n;
         busy_q  <= busy_n;
         err_q   <= err_n;
         last_q  <= last_n;
         bcnt_q  <= bcnt_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      order_n   = order_q;
      slot_n    = slot_q;
      sym_n     = sym_q;
      byte_n    = byte_q;
      grant_n   = grant_q;
      busy_n    = busy_q;
      err_n     = 1'b0;
      last_n    = last_q;
      bcnt_n    = bcnt_q;
      s0_ready  = 1'b0;
      s1_ready  = 1'b0;
      arb_upd_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|arb_gnt_c) begin
               s0_ready = arb_gnt_c[0];
               s1_ready = arb_gnt_c[1];
               byte_n   = sel_beat_c.data;
               last_n   = sel_beat_c.last;
               bcnt_n   = BCNT_W'(1);
               grant_n  = arb_gnt_c;
               busy_n   = 1'b1;
               slot_n   = '0;
               order_n  = ORD_SOF;
               state_n  = ST_SOF;
            end
         end
         ST_SOF: begin
            if (slot_q == SLOT_W'(SOF_CLKS - 1)) begin
               slot_n  = '0;
               sym_n   = '0;
               order_n = ORD_DATA;
               state_n = ST_DATA;
            end else begin
               slot_n = slot_q + SLOT_W'(1);
            end
         end
         ST_DATA: begin
            if (slot_q == SLOT_W'(SYM_CLKS - 1)) begin
               slot_n = '0;
               if (sym_q != SYM_W'(3)) begin
                  sym_n = sym_q + SYM_W'(1);
               end else if (last_q || (bcnt_q == BCNT_W'(MAX_BYTES))) begin
                  order_n = ORD_EOF;
                  state_n = ST_EOF;
               end else if (gnt_valid_c) begin
                  s0_ready = grant_q[0];
                  s1_ready = grant_q[1];
                  byte_n   = sel_beat_c.data;
                  last_n   = sel_beat_c.last;
                  bcnt_n   = bcnt_q + BCNT_W'(1);
                  sym_n    = '0;
               end else begin
                  // Owner ran dry mid-frame: close the frame and flag it.
                  err_n   = 1'b1;
                  order_n = ORD_EOF;
                  state_n = ST_EOF;
               end
            end else begin
               slot_n = slot_q + SLOT_W'(1);
            end
         end
         ST_EOF: begin
            if (slot_q == SLOT_W'(EOF_CLKS - 1)) begin
               slot_n  = '0;
               order_n = ORD_IDLE;
               state_n = ST_GAP;
            end else begin
               slot_n = slot_q + SLOT_W'(1);
            end
         end
         ST_GAP: begin
            if (slot_q == SLOT_W'(GAP_CLKS - 1)) begin
               slot_n    = '0;
               grant_n   = '0;
               busy_n    = 1'b0;
               arb_upd_c = 1'b1;
               state_n   = ST_IDLE;
            end else begin
               slot_n = slot_q + SLOT_W'(1);
            end
         end
         default: begin
            state_n = ST_IDLE;
            order_n = ORD_IDLE;
            busy_n  = 1'b0;
            grant_n = '0;
            slot_n  = '0;
         end
      endcase
   end

   assign order     = order_q;
   assign slot_cnt  = slot_q;
   assign sym_idx   = sym_q;
   assign tx_byte   = byte_q;
   assign grant     = grant_q;
   assign busy      = busy_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_ppm_frame_scheduler.sv
// Scoreboard bench: expected frames are queued with the stimulus and checked as each frame closes.
module tb_ppm_frame_scheduler;
   import ppm_pkg::*;

   localparam int SOF = 128;
   localparam int SYM = 128;
   localparam int EFL = 64;
   localparam int GAP = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       s0_valid, s0_last, s0_ready;
   logic       s1_valid, s1_last, s1_ready;
   logic [7:0] s0_data, s1_data;
   logic [1:0] order, sym_idx, grant;
   logic [9:0] slot_cnt;
   logic [7:0] tx_byte;
   logic       busy, frame_err;

   always #5 clk = ~clk;

   ppm_frame_scheduler #(
      .SOF_CLKS(SOF), .SYM_CLKS(SYM), .EOF_CLKS(EFL), .GAP_CLKS(GAP), .MAX_BYTES(16)
   ) dut (
      .clk(clk), .rst(rst),
      .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
      .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
      .order(order), .slot_cnt(slot_cnt), .sym_idx(sym_idx), .tx_byte(tx_byte),
      .grant(grant), .busy(busy), .frame_err(frame_err)
   );

   typedef struct {
      logic [1:0] gnt;
      int         n;
      int         err;
      logic [7:0] b [0:15];
   } exp_t;

   exp_t  exp_q[$];
   beat_t q0[$];
   beat_t q1[$];

   int n_chk = 0;
   int n_pass = 0;
   int stray_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
   endtask

   function automatic exp_t mk(input logic [1:0] g, input int n, input int err, input logic [7:0] first);
      exp_t e;
      e.gnt = g;
      e.n   = n;
      e.err = err;
      for (int i = 0; i < 16; i++) e.b[i] = (i < n) ? 8'(first + 8'(i)) : 8'h00;
      return e;
   endfunction

   task automatic send(input int src, input int n, input logic [7:0] first, input logic last_on_final);
      beat_t bt;
      for (int i = 0; i < n; i++) begin
         bt.data = 8'(first + 8'(i));
         bt.last = last_on_final && (i == n - 1);
         if (src == 0) q0.push_back(bt);
         else          q1.push_back(bt);
      end
   endtask

   // Source drivers: present queue heads, pop after each accepted beat.
   initial begin
      logic x0, x1;
      s0_valid = 1'b0; s0_data = 8'h00; s0_last = 1'b0;
      s1_valid = 1'b0; s1_data = 8'h00; s1_last = 1'b0;
      forever begin
         @(negedge clk);
         x0 = s0_valid && s0_ready && rst;
         x1 = s1_valid && s1_ready && rst;
         @(posedge clk);
         #1;
         if (x0 && q0.size() > 0) void'(q0.pop_front());
         if (x1 && q1.size() > 0) void'(q1.pop_front());
         s0_valid = (q0.size() > 0);
         if (s0_valid) begin s0_data = q0[0].data; s0_last = q0[0].last; end
         s1_valid = (q1.size() > 0);
         if (s1_valid) begin s1_data = q1[0].data; s1_last = q1[0].last; end
      end
   end

   // Frame monitor state
   logic       in_frame = 1'b0;
   logic       pre_rdy = 1'b0;
   logic       prev_busy = 1'b0;
   logic [1:0] fgnt;
   int sof_len, data_len, eof_len, gap_len, err_cnt, rdy_cnt, seq_bad, nb;
   logic [7:0] got_b [0:31];

   task automatic finish_frame();
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_frame", 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      chk("grant", 32'(fgnt), 32'(e.gnt));
      chk("sof_len", sof_len, SOF);
      chk("data_len", data_len, 4 * SYM * e.n);
      chk("eof_len", eof_len, EFL);
      chk("gap_len", gap_len, GAP);
      chk("nbytes", nb, e.n);
      for (int i = 0; i < e.n && i < nb; i++) chk($sformatf("byte%0d", i), 32'(got_b[i]), 32'(e.b[i]));
      chk("ready_pulses", rdy_cnt, e.n);
      chk("frame_err_cnt", err_cnt, e.err);
      chk("slot_sequence", seq_bad, 0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            in_frame = 1'b0; pre_rdy = 1'b0; prev_busy = 1'b0;
         end else begin
            if (in_frame && prev_busy && !busy) begin
               finish_frame();
               in_frame = 1'b0;
            end
            if (!in_frame && order == 2'b01) begin
               in_frame = 1'b1;
               fgnt = grant;
               rdy_cnt = pre_rdy ? 1 : 0;
               pre_rdy = 1'b0;
               sof_len = 0; data_len = 0; eof_len = 0; gap_len = 0;
               err_cnt = 0; seq_bad = 0; nb = 0;
            end
            if (in_frame) begin
               if (grant !== fgnt || !busy) seq_bad++;
               case (order)
                  2'b01: begin
                     if (slot_cnt != 10'(sof_len)) seq_bad++;
                     sof_len++;
                  end
                  2'b10: begin
                     if (slot_cnt != 10'(data_len % SYM)) seq_bad++;
                     if (sym_idx != 2'((data_len / SYM) % 4)) seq_bad++;
                     if ((data_len % (4 * SYM)) == 0 && nb < 32) begin
                        got_b[nb] = tx_byte;
                        nb++;
                     end
                     data_len++;
                  end
                  2'b11: begin
                     if (slot_cnt != 10'(eof_len)) seq_bad++;
                     eof_len++;
                  end
                  default: begin
                     if (slot_cnt != 10'(gap_len)) seq_bad++;
                     gap_len++;
                  end
               endcase
               if (s0_ready || s1_ready) begin
                  rdy_cnt++;
                  if ((s0_ready && !grant[0]) || (s1_ready && !grant[1]) || order != 2'b10 ||
                      slot_cnt != 10'(SYM - 1) || sym_idx != 2'd3) seq_bad++;
               end
               if (frame_err) begin
                  err_cnt++;
                  if (order != 2'b11 || slot_cnt != 10'd0) seq_bad++;
               end
            end else begin
               if (s0_ready || s1_ready) pre_rdy = 1'b1;
               if (frame_err) stray_err++;
            end
            prev_busy = busy;
         end
      end
   end

   task automatic wait_done(input string tag, input int limit);
      logic done;
      done = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && !busy && !in_frame) begin
            done = 1'b1;
            break;
         end
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      if (!done) exp_q.delete();
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic found;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_order", 32'(order), 32'd0);
      chk("rst_slot", 32'(slot_cnt), 32'd0);
      chk("rst_sym", 32'(sym_idx), 32'd0);
      chk("rst_tx_byte", 32'(tx_byte), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_ready", 32'({s1_ready, s0_ready}), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single byte from s0
      exp_q.push_back(mk(2'b01, 1, 0, 8'hB4));
      send(0, 1, 8'hB4, 1'b1);
      wait_done("single", 3000);

      // Both request after reset: s0 first, then s1
      pulse_reset();
      exp_q.push_back(mk(2'b01, 1, 0, 8'h11));
      exp_q.push_back(mk(2'b10, 1, 0, 8'h22));
      send(0, 1, 8'h11, 1'b1);
      send(1, 1, 8'h22, 1'b1);
      wait_done("tie", 5000);

      // s1 streams three bytes
      exp_q.push_back(mk(2'b10, 3, 0, 8'h01));
      send(1, 3, 8'h01, 1'b1);
      wait_done("stream", 5000);

      // Underrun after two bytes
      exp_q.push_back(mk(2'b01, 2, 1, 8'hA1));
      send(0, 2, 8'hA1, 1'b0);
      wait_done("underrun", 5000);

      // 20 bytes without last: capped at 16, remainder forms a new frame that underruns
      exp_q.push_back(mk(2'b01, 16, 0, 8'h40));
      exp_q.push_back(mk(2'b01, 4, 1, 8'h50));
      send(0, 20, 8'h40, 1'b0);
      wait_done("max_bytes", 20000);

      // Asynchronous reset in the middle of DATA
      send(0, 1, 8'hC3, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (order == 2'b10 && sym_idx == 2'd2) begin
            found = 1'b1;
            break;
         end
      end
      chk("reach_sym2", 32'(found), 32'd1);
      #3;
      rst = 1'b0;
      q0.delete();
      #1;
      chk("arst_order", 32'(order), 32'd0);
      chk("arst_slot", 32'(slot_cnt), 32'd0);
      chk("arst_sym", 32'(sym_idx), 32'd0);
      chk("arst_tx_byte", 32'(tx_byte), 32'd0);
      chk("arst_grant", 32'(grant), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_frame_err", 32'(frame_err), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      chk("no_eof_after_rst", 32'(order), 32'd0);
      chk("idle_after_rst", 32'(busy), 32'd0);
      exp_q.push_back(mk(2'b10, 1, 0, 8'h5A));
      send(1, 1, 8'h5A, 1'b1);
      wait_done("restart", 3000);

      chk("stray_frame_err", stray_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ppm_frame_scheduler.md
PPM_FRAME_SCHEDULER -- requirements
Module: ppm_frame_scheduler

Interface
REQ-001 Parameter: SOF_CLKS, default 128, SOF slot length in clk cycles.
REQ-002 Parameter: SYM_CLKS, default 128, length of one 2-bit PPM symbol slot in clk cycles.
REQ-003 Parameter: EOF_CLKS, default 64, EOF slot length in clk cycles.
REQ-004 Parameter: GAP_CLKS, default 16, idle gap after EOF in clk cycles.
REQ-005 Parameter: MAX_BYTES, default 16, maximum number of bytes per frame.
REQ-006 Port: clk  in  1  clock, rising edge.
REQ-007 Port: rst  in  1  asynchronous, active-low reset.
REQ-008 Ports: s0_valid / s1_valid  in  1  source byte available.
REQ-009 Ports: s0_data / s1_data  in  8  source byte.
REQ-010 Ports: s0_last / s1_last  in  1  byte is the last of the frame.
REQ-011 Ports: s0_ready / s1_ready  out  1  byte accepted; a transfer occurs on the edge where valid and ready are both high.
REQ-012 Port: order  out  2  encoder command: 00 IDLE, 01 SOF, 10 DATA, 11 EOF.
REQ-013 Port: slot_cnt  out  10  cycle index within the current slot.
REQ-014 Port: sym_idx  out  2  2-bit symbol index within tx_byte, LSB pair first.
REQ-015 Port: tx_byte  out  8  byte currently being encoded.
REQ-016 Port: grant  out  2  one-hot owner of the current frame; 00 when idle.
REQ-017 Port: busy  out  1  high in every state except IDLE.
REQ-018 Port: frame_err  out  1  one-cycle pulse on source underrun.

Function
REQ-019 FSM states SHALL be IDLE, SOF, DATA, EOF and GAP; all outputs except s*_ready SHALL be registered.
REQ-020 In IDLE, when either valid is high, the granted source SHALL be chosen round-robin: the pointer favours the source not served last, and a single requester wins regardless of the pointer.
REQ-021 s_ready of the chosen source SHALL be combinational on its valid in IDLE; the non-chosen source's ready SHALL stay 0.
REQ-022 On the IDLE transfer, the block SHALL load tx_byte and the last flag, set byte_cnt=1, set grant, and enter SOF with order=01 and slot_cnt=0 on the next cycle.
REQ-023 In SOF, slot_cnt SHALL count 0..SOF_CLKS-1; at SOF_CLKS-1 it SHALL enter DATA with slot_cnt=0 and sym_idx=0.
REQ-024 In DATA, slot_cnt SHALL count 0..SYM_CLKS-1; at SYM_CLKS-1, sym_idx SHALL increment and slot_cnt SHALL wrap to 0.
REQ-025 At slot_cnt=SYM_CLKS-1 with sym_idx=3, the following priority SHALL apply:
- last flag set or byte_cnt=MAX_BYTES -> EOF.
- else granted valid high -> ready high that cycle, load next byte, byte_cnt+1, sym_idx=0, stay in DATA.
- else -> frame_err pulse and EOF.
REQ-026 Outside REQ-021 and REQ-025, both s_ready outputs SHALL be 0.
REQ-027 In EOF, slot_cnt SHALL count 0..EOF_CLKS-1, then enter GAP.
REQ-028 In GAP, order SHALL be 00 and slot_cnt SHALL count 0..GAP_CLKS-1; the block SHALL then enter IDLE, clear grant and update the pointer.
REQ-029 Frame length SHALL be exactly SOF_CLKS + 4*SYM_CLKS*N + EOF_CLKS cycles of non-IDLE order, for N bytes.
REQ-030 In a single cycle, valid changes of the non-granted source SHALL have no effect during a frame.
REQ-031 byte_cnt SHALL be 5 bits wide and SHALL never exceed MAX_BYTES.

Reset
REQ-032 On rst low, regardless of state, the block SHALL set: order=00, slot_cnt=0, sym_idx=0, tx_byte=0, grant=00, busy=0, frame_err=0, pointer to source 0, state IDLE.
REQ-033 Reset SHALL take effect immediately, even mid-frame; no EOF SHALL be emitted.

Structure
REQ-034 Order encodings, FSM state encodings and default timing constants SHALL live in the shared package ppm_pkg.
REQ-035 The two-requester round-robin arbiter SHALL be the sub-module ppm_rr_arb; all counters and the FSM SHALL stay in ppm_frame_scheduler.

Verification
REQ-036 s0 sends 0xB4 with last=1 -> order shows 01 for 128 cycles, then 10 for 512 cycles (sym_idx 0,1,2,3 at tx_byte=0xB4), then 11 for 64 cycles, then 16 cycles of GAP; s0_ready is high for exactly one cycle.
REQ-037 s0 and s1 are both valid in IDLE after reset -> s0 is granted first; s1 is granted on the next frame.
REQ-038 s1 streams 0x01,0x02,0x03 with last on 0x03 -> three ready pulses, each at slot_cnt=127/sym_idx=3 after the first; the DATA phase lasts 1536 cycles.
REQ-039 s0 sends 2 bytes, then valid drops with no last -> one frame_err pulse and EOF immediately after the second byte.
REQ-040 s0 holds valid with last=0 for 20 bytes -> EOF after 16 bytes; the remaining 4 bytes start a new frame after GAP.
REQ-041 rst is asserted at DATA sym_idx=2 -> all outputs reach reset values asynchronously; the next valid restarts with SOF.
